// File: rtl/branch_cond_unit.sv
// Branch-condition unit: evaluates an IR condition code against the bus and holds the decision.
// Latency: 1 cycle from con_in to con_out/con_valid; the flag holds until the next evaluate or clear.
// Backpressure: none; evaluations are accepted every cycle, and con_clr overrides con_in.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   bus_in              datapath bus value
//   ir_cond             condition code taken from IR
//   con_in, con_clr     evaluate strobe and synchronous flag clear
//   load_a, load_cnt    latch bus_in into operand A / the loop counter
//   con_out, con_valid  registered decision and a one-cycle update pulse
//   cnt_out, cnt_zero   loop counter value and its zero flag
//   taken_cnt           saturating count of taken evaluations
//
// Optional feature: define BRANCH_COND_TAKEN_CNT_EN to build the taken counter.
// Without it, taken_cnt is tied to zero.
module branch_cond_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [2:0]        ir_cond,
  input  logic              con_in,
  input  logic              con_clr,
  input  logic              load_a,
  input  logic              load_cnt,
  output logic              con_out,
  output logic              con_valid,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              cnt_zero,
  output logic [15:0]       taken_cnt
);

  typedef enum logic [2:0] {
    COND_ZERO   = 3'b000,
    COND_NZERO  = 3'b001,
    COND_NONNEG = 3'b010,
    COND_NEG    = 3'b011,
    COND_ALWAYS = 3'b100,
    COND_NEVER  = 3'b101,
    COND_LOOP   = 3'b110,
    COND_EQ     = 3'b111
  } cond_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] a_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              result;
  logic              eval_ok;
  logic              loop_dec;

  // A clear in the same cycle cancels every side effect of the evaluation.
  assign eval_ok = con_in & ~con_clr;

  always_comb begin
    result = 1'b0;
    case (cond_e'(ir_cond))
      COND_ZERO:   result = (bus_in == '0);
      COND_NZERO:  result = (bus_in != '0);
      COND_NONNEG: result = ~bus_in[DATA_W-1];
      COND_NEG:    result = bus_in[DATA_W-1];
      COND_ALWAYS: result = 1'b1;
      COND_NEVER:  result = 1'b0;
      // Taken while the post-decrement count is still nonzero. A
      // simultaneous counter load wins and forces the result to not-taken.
      COND_LOOP:   result = (cnt_reg > CNT_ONE) & ~load_cnt;
      // Compares against A as it was before this edge, even when load_a is set.
      COND_EQ:     result = (bus_in == a_reg);
      default:     result = 1'b0;
    endcase
  end

  // The counter only ever decrements from a nonzero value, so it cannot wrap.
  assign loop_dec = eval_ok && (ir_cond == COND_LOOP) && (cnt_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      con_out   <= 1'b0;
      con_valid <= 1'b0;
      a_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      if (con_clr) begin
        con_out   <= 1'b0;
        con_valid <= 1'b0;
      end else if (con_in) begin
        con_out   <= result;
        con_valid <= 1'b1;
      end else begin
        con_valid <= 1'b0;
      end

      if (load_a) begin
        a_reg <= bus_in;
      end

      if (load_cnt) begin
        cnt_reg <= bus_in[CNT_W-1:0];
      end else if (loop_dec) begin
        cnt_reg <= cnt_reg - CNT_ONE;
      end
    end
  end

  assign cnt_out  = cnt_reg;
  assign cnt_zero = (cnt_reg == '0);

`ifdef BRANCH_COND_TAKEN_CNT_EN
  logic [15:0] taken_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_reg <= 16'h0000;
    end else if (eval_ok && result && (taken_reg != 16'hFFFF)) begin
      taken_reg <= taken_reg + 16'h0001;
    end
  end

  assign taken_cnt = taken_reg;
`else
  assign taken_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
module tb_branch_cond_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_in;
  logic [2:0]  ir_cond;
  logic        con_in;
  logic        con_clr;
  logic        load_a;
  logic        load_cnt;
  logic        con_out;
  logic        con_valid;
  logic [15:0] cnt_out;
  logic        cnt_zero;
  logic [15:0] taken_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        exp_q[$];
  logic [15:0] exp_taken = 16'h0000;

  branch_cond_unit #(.DATA_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .ir_cond   (ir_cond),
    .con_in    (con_in),
    .con_clr   (con_clr),
    .load_a    (load_a),
    .load_cnt  (load_cnt),
    .con_out   (con_out),
    .con_valid (con_valid),
    .cnt_out   (cnt_out),
    .cnt_zero  (cnt_zero),
    .taken_cnt (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every con_valid pulse consumes one expected decision.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && con_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_con_valid", 32'd1, 32'd0);
      end else begin
        check("con_out_eval", {31'd0, con_out}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle_inputs();
    bus_in   = '0;
    ir_cond  = 3'b000;
    con_in   = 1'b0;
    con_clr  = 1'b0;
    load_a   = 1'b0;
    load_cnt = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One evaluation; the expected decision is queued unless a clear suppresses it.
  task automatic eval(input logic [2:0] code, input logic [31:0] b, input logic la,
                      input logic lc, input logic clr, input logic exp_out);
    ir_cond  = code;
    bus_in   = b;
    con_in   = 1'b1;
    load_a   = la;
    load_cnt = lc;
    con_clr  = clr;
    if (!clr) begin
      exp_q.push_back(exp_out);
      if (exp_out && exp_taken != 16'hFFFF) exp_taken = exp_taken + 16'h0001;
    end
    step();
    idle_inputs();
  endtask

  task automatic load(input logic [31:0] b, input logic la, input logic lc);
    bus_in   = b;
    load_a   = la;
    load_cnt = lc;
    step();
    idle_inputs();
  endtask

  task automatic check_taken(input string name);
`ifdef BRANCH_COND_TAKEN_CNT_EN
    check(name, {16'd0, taken_cnt}, {16'd0, exp_taken});
`else
    check(name, {16'd0, taken_cnt}, 32'd0);
`endif
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    check("reset_con_out", {31'd0, con_out}, 32'd0);
    check("reset_con_valid", {31'd0, con_valid}, 32'd0);
    check("reset_cnt_out", {16'd0, cnt_out}, 32'd0);
    check("reset_cnt_zero", {31'd0, cnt_zero}, 32'd1);
    check_taken("reset_taken_cnt");
    rst_n = 1'b1;
    step();

    // Build some state, then assert reset between clock edges.
    eval(3'b100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(32'd5, 1'b0, 1'b1);
    check("pre_reset_cnt_out", {16'd0, cnt_out}, 32'd5);
    check("pre_reset_con_out", {31'd0, con_out}, 32'd1);
    #1 rst_n = 1'b0;
    exp_taken = 16'h0000;
    #1;
    check("async_reset_con_out", {31'd0, con_out}, 32'd0);
    check("async_reset_cnt_out", {16'd0, cnt_out}, 32'd0);
    check("async_reset_cnt_zero", {31'd0, cnt_zero}, 32'd1);
    check_taken("async_reset_taken_cnt");
    step();
    rst_n = 1'b1;
    step();

    // Zero code, then the pulse must drop while con_out holds.
    eval(3'b000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("zero_con_valid_pulse", {31'd0, con_valid}, 32'd1);
    step();
    check("zero_con_valid_drop", {31'd0, con_valid}, 32'd0);
    check("zero_con_out_hold", {31'd0, con_out}, 32'd1);

    // Sign and zero codes.
    eval(3'b010, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    eval(3'b011, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    eval(3'b000, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    eval(3'b001, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    eval(3'b101, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    eval(3'b010, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) step();
    check("hold_after_con_in_drop", {31'd0, con_out}, 32'd1);

    // Loop mode: load 3 (upper bus bits ignored), then decrement to zero without wrapping.
    load(32'hABCD_0003, 1'b0, 1'b1);
    check("loop_load_cnt", {16'd0, cnt_out}, 32'd3);
    eval(3'b110, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("loop_cnt_2", {16'd0, cnt_out}, 32'd2);
    eval(3'b110, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("loop_cnt_1", {16'd0, cnt_out}, 32'd1);
    eval(3'b110, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("loop_cnt_0", {16'd0, cnt_out}, 32'd0);
    check("loop_cnt_zero_flag", {31'd0, cnt_zero}, 32'd1);
    eval(3'b110, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("loop_no_wrap", {16'd0, cnt_out}, 32'd0);
    check("loop_no_wrap_zero_flag", {31'd0, cnt_zero}, 32'd1);

    // Equal compare uses A from before a simultaneous load.
    load(32'd7, 1'b1, 1'b0);
    eval(3'b111, 32'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    eval(3'b111, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    eval(3'b111, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear beats evaluate: no pulse, flag cleared, no taken increment.
    eval(3'b100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    eval(3'b100, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_con_out", {31'd0, con_out}, 32'd0);
    check("clr_con_valid", {31'd0, con_valid}, 32'd0);
    check_taken("clr_taken_cnt");

    // Counter load beats a loop decrement and forces a not-taken result.
    load(32'd2, 1'b0, 1'b1);
    eval(3'b110, 32'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    check("load_vs_loop_cnt", {16'd0, cnt_out}, 32'd4);
    check("load_vs_loop_valid", {31'd0, con_valid}, 32'd1);
    check("load_vs_loop_out", {31'd0, con_out}, 32'd0);
    // A cleared loop evaluation does not decrement.
    eval(3'b110, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_loop_no_dec", {16'd0, cnt_out}, 32'd4);

    // Taken counter over a run of always-taken evaluations.
    rst_n = 1'b0;
    exp_taken = 16'h0000;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) eval(3'b100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_taken("taken_cnt_5");
`ifdef BRANCH_COND_TAKEN_CNT_EN
    check("taken_cnt_5_abs", {16'd0, taken_cnt}, 32'd5);
    while (exp_taken < 16'hFFFE) eval(3'b100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("taken_cnt_fffe", {16'd0, taken_cnt}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) eval(3'b100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("taken_cnt_saturate", {16'd0, taken_cnt}, 32'h0000_FFFF);
`else
    check("taken_cnt_tied_zero", {16'd0, taken_cnt}, 32'd0);
`endif

    repeat (2) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Registered, parametrised branch-condition unit for the datapath control path. It evaluates one of eight condition codes against the value on the bus and holds the branch decision in a flag register until the next evaluation or clear. Beyond the single-operand tests it adds a loop-counter mode (decrement-and-test) and an equality compare against a latched operand. The control unit reads `con_out` to select the next PC.

## Interface
Parameters:
- `DATA_W`, 32: bus width.
- `CNT_W`, 16: loop-counter width; must be ≤ `DATA_W`.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `bus_in` in `DATA_W`: value on the datapath bus.
- `ir_cond` in 3: condition code taken from IR.
- `con_in` in 1: evaluate strobe.
- `con_clr` in 1: synchronous clear of the flag.
- `load_a` in 1: latch `bus_in` into operand register A.
- `load_cnt` in 1: latch `bus_in[CNT_W-1:0]` into the loop counter.
- `con_out` out 1: registered branch decision.
- `con_valid` out 1: one-cycle pulse when `con_out` is updated by an evaluation.
- `cnt_out` out `CNT_W`: current loop-counter value.
- `cnt_zero` out 1: high when the counter is 0 (combinational from the register).
- `taken_cnt` out 16: count of taken evaluations (see Configuration).

## Operation
- Reset (`rst_n` low, asynchronous) sets all of the following to 0: `con_out`, `con_valid`, A, counter, `taken_cnt`. `cnt_zero` is therefore 1.
- Condition codes, evaluated only on a cycle with `con_in=1`:
  - 000: zero, `bus_in==0`.
  - 001: nonzero.
  - 010: nonnegative, `bus_in[DATA_W-1]==0`.
  - 011: negative, MSB=1.
  - 100: always, 1.
  - 101: never, 0.
  - 110: loop.
    - Counter > 0: counter ← counter−1, result = (counter−1 ≠ 0), i.e. counter > 1.
    - Counter = 0: counter stays 0 (no wrap), result 0.
  - 111: equal, `bus_in == A` using the pre-edge value of A.
- Evaluation cycle: `con_out` ← result and `con_valid` ← 1. On every other cycle `con_valid` ← 0 and `con_out` holds its value; it is not cleared when `con_in` drops.
- `con_clr=1` forces `con_out` ← 0 and `con_valid` ← 0. `con_clr` has priority over a simultaneous `con_in`; in that case there is no counter decrement and no `taken_cnt` increment.
- `load_a`: A ← `bus_in`. If `load_a` coincides with `con_in` at code 111, the compare uses the old A and A updates on the same edge.
- `load_cnt`: counter ← `bus_in[CNT_W-1:0]`, upper bits ignored.
  - `load_cnt` beats a loop-mode decrement in the same cycle: the counter takes the loaded value.
  - That evaluation's result is forced to 0, and `con_valid` still pulses.
- `load_a`/`load_cnt` asserted with `con_in` at any other code operate independently.
- No arithmetic carries out of the counter. Decrement is only ever applied to a nonzero value.

## Timing
- Latency 1: inputs sampled on edge N produce `con_out`/`con_valid` from edge N.
- `con_out` holds until the next evaluate or clear edge.
- Back-to-back `con_in` every cycle is supported; each cycle produces a `con_valid` pulse.
- Reset asserted mid-sequence clears state immediately without waiting for a clock. Release is synchronised externally by the reset tree.
- `cnt_zero` follows the counter register in the same cycle, with no extra latency.

## Configuration
- `BRANCH_COND_TAKEN_CNT_EN` defined:
  - `taken_cnt` increments by 1 on every evaluation edge with result 1 that is not suppressed by `con_clr`.
  - It saturates at 16'hFFFF and is cleared only by reset.
- Not defined: `taken_cnt` is tied to 16'h0000 and no counter logic is generated.

## Test plan
- Reset then evaluate:
  - Assert `rst_n=0` mid-run → all outputs 0, `cnt_zero=1`.
  - Release, then `con_in`, code 000, bus=0 → next edge `con_out=1`, `con_valid` one-cycle pulse.
- Sign/zero codes with `DATA_W=32`:
  - bus=32'h8000_0000 with codes 010/011 → 0/1.
  - bus=5 with codes 000/001 → 0/1.
  - `con_out` holds after `con_in` deasserts.
- Loop mode:
  - `load_cnt` with bus=3, then three code-110 evaluations → `con_out` 1,1,0, counter 2,1,0.
  - A fourth evaluation → `con_out=0`, counter stays 0, `cnt_zero=1`.
- Equal compare with simultaneous load:
  - A=7. `load_a` with bus=9 plus `con_in` code 111 → `con_out=0`, A=9.
  - Next evaluation with bus=9 → `con_out=1`.
- Priority:
  - `con_in` code 100 with `con_clr` → `con_out=0`, no `con_valid`, `taken_cnt` unchanged.
  - `load_cnt` bus=4 with loop evaluation at counter 2 → counter=4, `con_out=0`, `con_valid=1`.
- With `BRANCH_COND_TAKEN_CNT_EN`:
  - 5 code-100 evaluations → `taken_cnt=5`.
  - Preload to 16'hFFFE by forcing, then 3 takens → 16'hFFFF.
  - Without the macro → `taken_cnt=0` throughout.
